// File: rtl/wishbone_arbiter_pkg.sv
// Shared Wishbone bus types for the LC-3b memory arbiter.
package lc3b_types;

    typedef logic [11:0]  lc3b_wb_adr;
    typedef logic [15:0]  lc3b_wb_sel;
    typedef logic [127:0] lc3b_wb_dat;

    typedef enum logic [1:0] {
        arb_none = 2'd0,
        arb_inst = 2'd1,
        arb_data = 2'd2
    } lc3b_arb_owner;

endpackage

// File: rtl/wishbone_arbiter.sv
// Two-master Wishbone arbiter (instruction/data) in front of one memory slave.
// Alternating priority on contention, one idle turnaround cycle between grants.
module wishbone_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst,

    input  logic          imem_CYC,
    input  logic          imem_STB,
    input  logic          imem_WE,
    input  lc3b_wb_adr    imem_ADR,
    input  lc3b_wb_sel    imem_SEL,
    input  lc3b_wb_dat    imem_DAT_M,
    output logic          imem_ACK,
    output logic          imem_RTY,
    output lc3b_wb_dat    imem_DAT_S,

    input  logic          dmem_CYC,
    input  logic          dmem_STB,
    input  logic          dmem_WE,
    input  lc3b_wb_adr    dmem_ADR,
    input  lc3b_wb_sel    dmem_SEL,
    input  lc3b_wb_dat    dmem_DAT_M,
    output logic          dmem_ACK,
    output logic          dmem_RTY,
    output lc3b_wb_dat    dmem_DAT_S,

    output logic          mem_CYC,
    output logic          mem_STB,
    output logic          mem_WE,
    output lc3b_wb_adr    mem_ADR,
    output lc3b_wb_sel    mem_SEL,
    output lc3b_wb_dat    mem_DAT_M,
    input  logic          mem_ACK,
    input  logic          mem_RTY,
    input  lc3b_wb_dat    mem_DAT_S,

    output lc3b_arb_owner grant_owner
);

    localparam logic [1:0] s_idle = 2'd0;
    localparam logic [1:0] s_inst = 2'd1;
    localparam logic [1:0] s_data = 2'd2;

    logic [1:0]    state_q, state_d;
    lc3b_arb_owner last_grant_q, last_grant_d;

    logic inst_req, data_req;
    logic own_inst, own_data;

    assign inst_req = imem_CYC & imem_STB;
    assign data_req = dmem_CYC & dmem_STB;

    // An abort (owner drops CYC) wins over a same-cycle mem_ACK and leaves last_grant alone.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            s_idle: begin
                if (inst_req && data_req)
                    state_d = (last_grant_q == arb_data) ? s_inst : s_data;
                else if (inst_req)
                    state_d = s_inst;
                else if (data_req)
                    state_d = s_data;
            end
            s_inst: begin
                if (!imem_CYC) begin
                    state_d = s_idle;
                end else if (mem_ACK) begin
                    state_d      = s_idle;
                    last_grant_d = arb_inst;
                end
            end
            s_data: begin
                if (!dmem_CYC) begin
                    state_d = s_idle;
                end else if (mem_ACK) begin
                    state_d      = s_idle;
                    last_grant_d = arb_data;
                end
            end
            default: state_d = s_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= s_idle;
            last_grant_q <= arb_inst;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Reset also masks the outputs combinationally so nothing leaks during the reset cycle.
    assign own_inst = ~rst & (state_q == s_inst);
    assign own_data = ~rst & (state_q == s_data);

    always_comb begin
        mem_CYC   = 1'b0;
        mem_STB   = 1'b0;
        mem_WE    = 1'b0;
        mem_ADR   = '0;
        mem_SEL   = '0;
        mem_DAT_M = '0;
        if (own_inst) begin
            mem_CYC   = imem_CYC;
            mem_STB   = imem_STB;
            mem_WE    = imem_WE;
            mem_ADR   = imem_ADR;
            mem_SEL   = imem_SEL;
            mem_DAT_M = imem_DAT_M;
        end else if (own_data) begin
            mem_CYC   = dmem_CYC;
            mem_STB   = dmem_STB;
            mem_WE    = dmem_WE;
            mem_ADR   = dmem_ADR;
            mem_SEL   = dmem_SEL;
            mem_DAT_M = dmem_DAT_M;
        end
    end

    assign imem_ACK   = own_inst & imem_CYC & mem_ACK;
    assign imem_RTY   = own_inst ? (imem_CYC & mem_RTY) : (~rst & inst_req);
    assign imem_DAT_S = own_inst ? mem_DAT_S : '0;

    assign dmem_ACK   = own_data & dmem_CYC & mem_ACK;
    assign dmem_RTY   = own_data ? (dmem_CYC & mem_RTY) : (~rst & data_req);
    assign dmem_DAT_S = own_data ? mem_DAT_S : '0;

    assign grant_owner = rst ? arb_none : lc3b_arb_owner'(state_q);

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed self-checking bench for wishbone_arbiter.
module tb_wishbone_arbiter;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_CYC, imem_STB, imem_WE;
    lc3b_wb_adr    imem_ADR;
    lc3b_wb_sel    imem_SEL;
    lc3b_wb_dat    imem_DAT_M;
    logic          imem_ACK, imem_RTY;
    lc3b_wb_dat    imem_DAT_S;
    logic          dmem_CYC, dmem_STB, dmem_WE;
    lc3b_wb_adr    dmem_ADR;
    lc3b_wb_sel    dmem_SEL;
    lc3b_wb_dat    dmem_DAT_M;
    logic          dmem_ACK, dmem_RTY;
    lc3b_wb_dat    dmem_DAT_S;
    logic          mem_CYC, mem_STB, mem_WE;
    lc3b_wb_adr    mem_ADR;
    lc3b_wb_sel    mem_SEL;
    lc3b_wb_dat    mem_DAT_M;
    logic          mem_ACK, mem_RTY;
    lc3b_wb_dat    mem_DAT_S;
    lc3b_arb_owner grant_owner;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam lc3b_wb_dat RDATA = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam lc3b_wb_dat WDATA = 128'h11112222_33334444_55556666_77778888;

    wishbone_arbiter dut (
        .clk(clk), .rst(rst),
        .imem_CYC(imem_CYC), .imem_STB(imem_STB), .imem_WE(imem_WE),
        .imem_ADR(imem_ADR), .imem_SEL(imem_SEL), .imem_DAT_M(imem_DAT_M),
        .imem_ACK(imem_ACK), .imem_RTY(imem_RTY), .imem_DAT_S(imem_DAT_S),
        .dmem_CYC(dmem_CYC), .dmem_STB(dmem_STB), .dmem_WE(dmem_WE),
        .dmem_ADR(dmem_ADR), .dmem_SEL(dmem_SEL), .dmem_DAT_M(dmem_DAT_M),
        .dmem_ACK(dmem_ACK), .dmem_RTY(dmem_RTY), .dmem_DAT_S(dmem_DAT_S),
        .mem_CYC(mem_CYC), .mem_STB(mem_STB), .mem_WE(mem_WE),
        .mem_ADR(mem_ADR), .mem_SEL(mem_SEL), .mem_DAT_M(mem_DAT_M),
        .mem_ACK(mem_ACK), .mem_RTY(mem_RTY), .mem_DAT_S(mem_DAT_S),
        .grant_owner(grant_owner)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input lc3b_arb_owner obs, input lc3b_arb_owner exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic on, input lc3b_wb_adr adr);
        imem_CYC = on; imem_STB = on; imem_WE = 1'b0;
        imem_ADR = adr; imem_SEL = 16'h000F; imem_DAT_M = '0;
    endtask

    task automatic set_data(input logic on, input logic we, input lc3b_wb_adr adr,
                            input lc3b_wb_sel sel, input lc3b_wb_dat dat);
        dmem_CYC = on; dmem_STB = on; dmem_WE = we;
        dmem_ADR = adr; dmem_SEL = sel; dmem_DAT_M = dat;
    endtask

    initial begin
        rst = 1'b1;
        set_inst(1'b1, 12'h0A3);
        set_data(1'b0, 1'b0, '0, '0, '0);
        mem_ACK = 1'b0; mem_RTY = 1'b0; mem_DAT_S = RDATA;
        tick();
        tick();
        // reset: requesters present, but nothing may leak out
        chk_o("rst_owner", grant_owner, arb_none);
        chk_b("rst_mem_cyc", mem_CYC, 1'b0);
        chk_b("rst_imem_ack", imem_ACK, 1'b0);
        chk_v("rst_imem_dat", imem_DAT_S, '0);
        chk_v("rst_mem_adr", 128'(mem_ADR), '0);

        // single instruction read, slave acks 3 cycles after grant
        rst = 1'b0;
        #1;
        chk_b("idle_imem_rty", imem_RTY, 1'b1);
        chk_b("idle_mem_cyc", mem_CYC, 1'b0);
        tick();
        chk_o("i1_owner", grant_owner, arb_inst);
        chk_b("i1_mem_cyc", mem_CYC, 1'b1);
        chk_v("i1_mem_adr", 128'(mem_ADR), 128'h0A3);
        chk_b("i1_imem_rty", imem_RTY, 1'b0);
        chk_b("i1_dmem_rty", dmem_RTY, 1'b0);
        tick();
        chk_b("i1_wait_ack", imem_ACK, 1'b0);
        tick();
        mem_ACK = 1'b1;
        #1;
        chk_b("i1_ack", imem_ACK, 1'b1);
        chk_v("i1_dat", imem_DAT_S, RDATA);
        chk_b("i1_dmem_ack", dmem_ACK, 1'b0);
        chk_v("i1_dmem_dat", dmem_DAT_S, '0);
        tick();
        mem_ACK = 1'b0;
        set_inst(1'b0, '0);
        #1;
        chk_o("i1_done_owner", grant_owner, arb_none);
        chk_b("i1_done_ack", imem_ACK, 1'b0);

        // simultaneous request straight after reset -> data first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_inst(1'b1, 12'h0A3);
        set_data(1'b1, 1'b0, 12'h155, 16'h00F0, '0);
        tick();
        chk_o("tie_owner", grant_owner, arb_data);
        chk_v("tie_mem_adr", 128'(mem_ADR), 128'h155);
        chk_b("tie_imem_rty", imem_RTY, 1'b1);
        chk_v("tie_imem_dat", imem_DAT_S, '0);
        mem_ACK = 1'b1;
        #1;
        chk_b("tie_dmem_ack", dmem_ACK, 1'b1);
        chk_b("tie_imem_ack", imem_ACK, 1'b0);
        tick();
        mem_ACK = 1'b0;
        set_data(1'b0, 1'b0, '0, '0, '0);
        #1;
        chk_o("tie_turn_owner", grant_owner, arb_none);
        chk_b("tie_turn_rty", imem_RTY, 1'b1);
        chk_b("tie_turn_cyc", mem_CYC, 1'b0);
        tick();
        chk_o("tie_inst_owner", grant_owner, arb_inst);
        chk_v("tie_inst_adr", 128'(mem_ADR), 128'h0A3);
        mem_ACK = 1'b1;
        tick();
        mem_ACK = 1'b0;

        // continuous contention, last grant was inst: data, inst, data, inst
        set_inst(1'b1, 12'h0A3);
        set_data(1'b1, 1'b0, 12'h155, 16'h00F0, '0);
        #1;
        chk_o("alt_idle", grant_owner, arb_none);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_o("alt_owner", grant_owner, (i % 2 == 0) ? arb_data : arb_inst);
            mem_ACK = 1'b1;
            #1;
            chk_b("alt_owner_ack", (i % 2 == 0) ? dmem_ACK : imem_ACK, 1'b1);
            chk_b("alt_other_ack", (i % 2 == 0) ? imem_ACK : dmem_ACK, 1'b0);
            tick();
            mem_ACK = 1'b0;
            #1;
            chk_o("alt_gap", grant_owner, arb_none);
        end
        set_inst(1'b0, '0);
        set_data(1'b0, 1'b0, '0, '0, '0);

        // data write with two retry cycles
        set_data(1'b1, 1'b1, 12'h7FF, 16'hFFFF, WDATA);
        tick();
        chk_o("wr_owner", grant_owner, arb_data);
        chk_b("wr_we", mem_WE, 1'b1);
        chk_v("wr_sel", 128'(mem_SEL), 128'hFFFF);
        chk_v("wr_dat", mem_DAT_M, WDATA);
        mem_RTY = 1'b1;
        #1;
        chk_b("wr_rty1", dmem_RTY, 1'b1);
        chk_b("wr_noack1", dmem_ACK, 1'b0);
        tick();
        chk_o("wr_hold1", grant_owner, arb_data);
        chk_b("wr_rty2", dmem_RTY, 1'b1);
        tick();
        chk_o("wr_hold2", grant_owner, arb_data);
        mem_RTY = 1'b0;
        mem_ACK = 1'b1;
        #1;
        chk_b("wr_ack", dmem_ACK, 1'b1);
        chk_b("wr_rty_off", dmem_RTY, 1'b0);
        tick();
        mem_ACK = 1'b0;
        #1;
        chk_o("wr_done", grant_owner, arb_none);
        // last grant is data now, so a tie must go to inst
        set_inst(1'b1, 12'h0A3);
        tick();
        chk_o("wr_last_data", grant_owner, arb_inst);
        set_data(1'b0, 1'b0, '0, '0, '0);

        // reset while inst owns the bus, ack arrives after the reset edge
        rst = 1'b1;
        #1;
        chk_b("rmid_during_cyc", mem_CYC, 1'b0);
        tick();
        rst = 1'b0;
        mem_ACK = 1'b1;
        #1;
        chk_b("rmid_cyc", mem_CYC, 1'b0);
        chk_b("rmid_imem_ack", imem_ACK, 1'b0);
        chk_b("rmid_dmem_ack", dmem_ACK, 1'b0);
        chk_o("rmid_owner", grant_owner, arb_none);
        mem_ACK = 1'b0;
        set_inst(1'b0, '0);
        tick();

        // data aborts with inst waiting; same-cycle ack must be ignored
        set_data(1'b1, 1'b0, 12'h200, 16'h0F00, '0);
        tick();
        chk_o("ab_owner", grant_owner, arb_data);
        set_inst(1'b1, 12'h0A3);
        #1;
        chk_b("ab_imem_rty", imem_RTY, 1'b1);
        set_data(1'b0, 1'b0, '0, '0, '0);
        mem_ACK = 1'b1;
        #1;
        chk_b("ab_ack_ignored", dmem_ACK, 1'b0);
        chk_b("ab_cyc_low", mem_CYC, 1'b0);
        tick();
        mem_ACK = 1'b0;
        #1;
        chk_o("ab_idle", grant_owner, arb_none);
        tick();
        chk_o("ab_inst_owner", grant_owner, arb_inst);
        chk_v("ab_inst_adr", 128'(mem_ADR), 128'h0A3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have ports: clk input 1 (system clock); rst input 1 (synchronous, active-high reset; one clock domain).
REQ-002 SHALL have instruction master ports: imem_CYC, imem_STB, imem_WE input 1; imem_ADR input 12; imem_SEL input 16; imem_DAT_M input 128; imem_ACK, imem_RTY output 1; imem_DAT_S output 128.
REQ-003 SHALL have data master ports: dmem_CYC, dmem_STB, dmem_WE input 1; dmem_ADR input 12; dmem_SEL input 16; dmem_DAT_M input 128; dmem_ACK, dmem_RTY output 1; dmem_DAT_S output 128.
REQ-004 SHALL have slave ports: mem_CYC, mem_STB, mem_WE output 1; mem_ADR output 12; mem_SEL output 16; mem_DAT_M output 128; mem_ACK, mem_RTY input 1; mem_DAT_S input 128.
REQ-005 SHALL provide grant_owner output lc3b_arb_owner (none/inst/data), for debug and pipeline stall logic.

Function
REQ-006 SHALL implement states s_idle, s_inst, s_data; owner equals state.
REQ-007 A master requests when CYC&STB high; requests held until ACK or withdrawn.
REQ-008 In s_idle, SHALL grant on the next edge: only one requester -> that one; both -> master not granted last (last_grant register); ties after reset -> data.
REQ-009 In s_idle, slave outputs SHALL be zero; both masters see RTY=1 if requesting, ACK=0.
REQ-010 In s_inst/s_data, slave CYC/STB/WE/ADR/SEL/DAT_M SHALL combinationally mirror owner; owner DAT_S mirrors mem_DAT_S; owner ACK/RTY mirror mem_ACK/mem_RTY.
REQ-011 Non-owner master SHALL see ACK=0 and RTY=1 while requesting, RTY=0 otherwise; its DAT_S SHALL be zero.
REQ-012 Owner transition on mem_ACK: next state s_idle, last_grant <= owner; minimum one idle turnaround cycle between grants.
REQ-013 mem_RTY without ACK SHALL hold grant (no state change).
REQ-014 Owner dropping CYC before ACK (abort) SHALL return to s_idle next edge without updating last_grant; mem_ACK in that cycle SHALL be ignored.
REQ-015 Grant SHALL never change while mem_CYC is high and mem_ACK low.
REQ-016 Latency: request in idle -> slave CYC 1 cycle later; single-requester round trip = 1 + slave latency.
REQ-017 Starvation bound: a continuously requesting master SHALL be granted within one competing transaction.

Reset
REQ-018 rst sampled at posedge clk: state <= s_idle, last_grant <= inst, overriding any in-flight transaction.
REQ-019 During and after reset cycle all slave outputs, ACKs, DAT_S SHALL be 0; grant_owner = none.
REQ-020 Reset mid-transaction SHALL drop mem_CYC at the edge; late mem_ACK SHALL not reach either master.

Structure
REQ-021 lc3b_types SHALL add lc3b_wb_adr (12), lc3b_wb_sel (16), lc3b_wb_dat (128), enum lc3b_arb_owner {arb_none, arb_inst, arb_data}.
REQ-022 Single module: registered state and last_grant plus combinational muxing; no sub-module.
REQ-023 No combinational path from mem_ACK to mem_CYC/STB.

Verification
REQ-024 Single inst read ADR=12'h0A3, slave ACK after 3 cycles with DAT_S=128'hDEAD... -> imem_ACK one cycle, imem_DAT_S matches, dmem_ACK never high.
REQ-025 Both request same cycle after reset -> data granted first (mem_ADR=dmem_ADR), imem_RTY=1 throughout, inst granted after one idle cycle.
REQ-026 Both continuously requesting, 4 transactions -> grants alternate data, inst, data, inst.
REQ-027 Data write WE=1 SEL=16'hFFFF, slave RTY two cycles then ACK -> grant held, dmem_RTY mirrors, one ACK, last_grant=data.
REQ-028 rst during s_inst before ACK, ACK arrives next cycle -> mem_CYC=0 post-edge, imem_ACK=0, state s_idle.
REQ-029 Data aborts (CYC low) mid-transaction with inst waiting -> s_idle next edge, inst granted following edge.
